// File: rtl/mux5_rr_arbiter.sv
// mux5_rr_arbiter: round-robin owner selection for the shared 5:1 mux.
// One requester owns the mux at a time. sel carries the owner index, or
// the idle code 3'b101 (mux output forced to 0) when nobody is granted.
// A single owner holds the mux for at most HOLD_MAX consecutive cycles.
module mux5_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Holds 0..HOLD_MAX-1; one spare code keeps HOLD_MAX=1 at a legal width.
  localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]        SEL_IDLE = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Request bit for an index; codes outside 0..4 read as "not requesting".
  function automatic logic req_at(input logic [4:0] r, input logic [2:0] idx);
    logic bit_v;
    case (idx)
      3'd0:    bit_v = r[0];
      3'd1:    bit_v = r[1];
      3'd2:    bit_v = r[2];
      3'd3:    bit_v = r[3];
      3'd4:    bit_v = r[4];
      default: bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

  // One-hot grant vector for an owner index; invalid codes give no grant.
  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    logic [4:0] oh;
    case (idx)
      3'd0:    oh = 5'b00001;
      3'd1:    oh = 5'b00010;
      3'd2:    oh = 5'b00100;
      3'd3:    oh = 5'b01000;
      3'd4:    oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

  // Round-robin start point following a winner (4 wraps back to 0).
  function automatic logic [2:0] ptr_after(input logic [2:0] idx);
    logic [2:0] nxt;
    case (idx)
      3'd0:    nxt = 3'd1;
      3'd1:    nxt = 3'd2;
      3'd2:    nxt = 3'd3;
      3'd3:    nxt = 3'd4;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  // Search ptr, ptr+1, ... mod 5; returns {found, winner index}.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [3:0] sum;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      sum = {1'b0, p} + 4'(i);
      if (sum >= 4'd5) begin
        idx = 3'(sum - 4'd5);
      end else begin
        idx = sum[2:0];
      end
      if (!res[3] && req_at(r, idx)) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t           r_state;
  logic [4:0]       r_grant;
  logic [2:0]       r_sel;
  logic             r_busy;
  logic             r_timeout;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [4:0]       w_grant_nxt;
  logic [2:0]       w_sel_nxt;
  logic             w_busy_nxt;
  logic             w_timeout_nxt;
  logic [2:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [3:0]       w_pick;
  logic             w_win;
  logic [2:0]       w_win_idx;
  logic             w_owner_req;
  logic             w_hold_hit;

  // The owner is the registered sel value while in GRANT. Both the IDLE
  // search and the release search start from r_ptr, which was already
  // advanced past the current owner when its grant was issued, so a
  // timed-out owner is found last and only wins again when alone.
  assign w_pick      = rr_pick(req, r_ptr);
  assign w_win       = w_pick[3];
  assign w_win_idx   = w_pick[2:0];
  assign w_owner_req = req_at(req, r_sel);
  assign w_hold_hit  = (r_cnt == CNT_LAST);

  // Next-state, grant hand-off and hold counting.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_win) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = onehot5(w_win_idx);
          w_sel_nxt   = w_win_idx;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = ptr_after(w_win_idx);
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 5'b00000;
          w_sel_nxt   = SEL_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end

      ST_GRANT: begin
        if (!w_owner_req || w_hold_hit) begin
          // Release: owner dropped, or it used up its hold budget.
          w_timeout_nxt = w_owner_req;
          if (w_win) begin
            w_state_nxt = ST_GRANT;
            w_grant_nxt = onehot5(w_win_idx);
            w_sel_nxt   = w_win_idx;
            w_busy_nxt  = 1'b1;
            w_ptr_nxt   = ptr_after(w_win_idx);
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 5'b00000;
            w_sel_nxt   = SEL_IDLE;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle.
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 5'b00000;
        w_sel_nxt   = SEL_IDLE;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = 3'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= 5'b00000;
      r_sel     <= SEL_IDLE;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 3'd0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
